ltssm_detect_multi: RTL and testbench
=====================================

// Module: ltssm_detect_multi
// PURPOSE
//   Parametrised multi-lane LTSSM Detect substate controller (Detect.Quiet / Detect.Active).
//   Sits between the LTSSM top and the PHY receiver-detect logic. Handles per-lane electrical-idle exit,
//   the receiver-detect request/done handshake with timeout, and the partial-detect 12 ms retry rule.
//   Reports the set of lanes that detected a receiver on exit to Polling.
// PARAMETERS
//   NUM_LANES      4        number of lanes handled (1..32)
//   QUIET_CYCLES   3000000  clk cycles in the 12 ms quiet/retry interval (12 ms at 250 MHz); >= 2
//   RXDET_TIMEOUT  1024     max clk cycles to wait for rxdet_done_i before treating as "no receiver"
// PORTS
//   clk_i             in   1          clock
//   rst_ni            in   1          asynchronous reset, active low
//   restart_i         in   1          pulse: force return to QUIET (LTSSM re-entry into Detect)
//   lane_en_i         in   NUM_LANES  unconfigured lanes to be probed; others ignored
//   elec_idle_i       in   NUM_LANES  1 = lane in electrical idle
//   rxdet_req_o       out  1          request PHY receiver-detect sequence on lane_en_i lanes
//   rxdet_done_i      in   1          PHY: detect sequence complete, rxdet_result_i valid this cycle
//   rxdet_result_i    in   NUM_LANES  PHY: 1 = receiver present on lane
//   active_o          out  1          1 while in ACTIVE1 or ACTIVE2
//   detect_done_o     out  1          1-cycle pulse on entry to DONE (go to Polling)
//   lanes_detected_o  out  NUM_LANES  lanes to carry into Polling; valid while in DONE
//   state_o           out  3          current state encoding (debug)
// BEHAVIOUR
//   Reset: state QUIET (0), timer 0, rxdet_req_o 0, active_o 0, detect_done_o 0,
//     lanes_detected_o 0, first-pass mask 0. Reset mid-operation aborts any handshake immediately.
//   States / encoding: QUIET=0, ACTIVE1=1, WAIT=2, ACTIVE2=3, DONE=4. All other codes -> QUIET.
//   Timer: one up-counter, width $clog2(max(QUIET_CYCLES,RXDET_TIMEOUT)+1); cleared on every
//     state change; saturates at its maximum, never wraps.
//   QUIET: timer runs. -> ACTIVE1 when timer == QUIET_CYCLES-1, or when
//     |(~elec_idle_i & lane_en_i) is 1 (sampled, transition next edge). lane_en_i==0 disables idle exit.
//   ACTIVE1/ACTIVE2: rxdet_req_o = 1 from the first cycle in state until the cycle rxdet_done_i is
//     sampled 1 (inclusive); deasserted next cycle. done_i while not active is ignored.
//     r = rxdet_result_i & lane_en_i, captured when rxdet_done_i = 1.
//     Timeout: timer == RXDET_TIMEOUT-1 with no done -> treat as r = 0.
//   ACTIVE1 decision: lane_en_i==0 or r==0 -> QUIET; r==lane_en_i -> DONE, lanes_detected_o=r;
//     otherwise store first mask = r -> WAIT.
//   WAIT: timer runs, no request; -> ACTIVE2 when timer == QUIET_CYCLES-1. Electrical idle ignored.
//   ACTIVE2 decision: r == first mask -> DONE, lanes_detected_o=r; else (incl. timeout) -> QUIET.
//   DONE: detect_done_o high on first cycle only; lanes_detected_o held; stays until restart_i.
//   restart_i has priority over every other transition in every state (incl. DONE and same-cycle
//     rxdet_done_i): -> QUIET, req dropped, lanes_detected_o and first mask cleared, timer 0.
//   Latency: decision -> next state one edge after rxdet_done_i sample; detect_done_o asserted the
//     cycle after the done_i sample that produces DONE.
//   lane_en_i is sampled live; the bench holds it stable outside QUIET.
// TESTING (QUIET_CYCLES=20, RXDET_TIMEOUT=8, NUM_LANES=4)
//   Reset, lane_en=4'hF, idle=4'hF -> ACTIVE1 after 20 cycles, rxdet_req_o=1 on that cycle.
//   QUIET, idle goes 4'hB on cycle 5 -> ACTIVE1 next edge; done with result 4'hF ->
//     DONE, detect_done_o 1-cycle pulse, lanes_detected_o=4'hF.
//   ACTIVE1 result 4'h3 -> WAIT 20 cycles -> ACTIVE2 result 4'h3 -> DONE, lanes_detected_o=4'h3;
//     repeat with ACTIVE2 result 4'h1 -> QUIET, lanes_detected_o=0.
//   No rxdet_done_i in ACTIVE1 -> rxdet_req_o drops and state QUIET after 8 cycles; result 0 -> QUIET.
//   restart_i coincident with rxdet_done_i (result 4'hF) -> QUIET, no detect_done_o pulse.
//   rst_ni low mid-WAIT -> all outputs 0 immediately; lane_en=0 -> never exits ACTIVE1 to DONE.

Source files
------------

// File: rtl/ltssm_detect_multi.sv
// ----------------------------------------------------------------------------
// ltssm_detect_multi
//   Multi-lane LTSSM Detect substate controller (Detect.Quiet / Detect.Active).
//   Sits between the LTSSM top and the PHY receiver-detect logic. It handles
//   per-lane electrical-idle exit and the receiver-detect request/done
//   handshake with a timeout. It also applies the partial-detect retry rule:
//   when only some lanes respond, it waits one quiet interval, probes again,
//   and accepts the result only if the same lanes respond the second time.
//
// Ports
//   clk_i             clock
//   rst_ni            asynchronous reset, active low
//   restart_i         pulse: force return to QUIET (re-entry into Detect)
//   lane_en_i         lanes to probe; other lanes are ignored
//   elec_idle_i       1 = lane in electrical idle
//   rxdet_req_o       request a PHY receiver-detect sequence
//   rxdet_done_i      PHY: detect sequence complete, rxdet_result_i valid
//   rxdet_result_i    PHY: 1 = receiver present on lane
//   active_o          1 while in ACTIVE1 or ACTIVE2
//   detect_done_o     1-cycle pulse on entry to DONE
//   lanes_detected_o  lanes carried into Polling, valid while in DONE
//   state_o           current state encoding (debug)
// ----------------------------------------------------------------------------
module ltssm_detect_multi #(
    parameter int NUM_LANES     = 4,
    parameter int QUIET_CYCLES  = 3000000,
    parameter int RXDET_TIMEOUT = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 restart_i,
    input  logic [NUM_LANES-1:0] lane_en_i,
    input  logic [NUM_LANES-1:0] elec_idle_i,
    output logic                 rxdet_req_o,
    input  logic                 rxdet_done_i,
    input  logic [NUM_LANES-1:0] rxdet_result_i,
    output logic                 active_o,
    output logic                 detect_done_o,
    output logic [NUM_LANES-1:0] lanes_detected_o,
    output logic [2:0]           state_o
);

    localparam int MAXV = (QUIET_CYCLES > RXDET_TIMEOUT) ? QUIET_CYCLES : RXDET_TIMEOUT;
    localparam int TW   = $clog2(MAXV + 1);

    localparam logic [TW-1:0] Q_LAST  = TW'(QUIET_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(RXDET_TIMEOUT - 1);
    localparam logic [TW-1:0] T_MAX   = {TW{1'b1}};

    typedef enum logic [2:0] {
        QUIET   = 3'd0,
        ACTIVE1 = 3'd1,
        WAIT    = 3'd2,
        ACTIVE2 = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [NUM_LANES-1:0] first_q, first_d;
    logic [NUM_LANES-1:0] lanes_q, lanes_d;
    logic                 pulse_q, pulse_d;

    logic [NUM_LANES-1:0] r;
    logic                 decide;

    // A timeout is a decision with an empty result.
    assign r      = rxdet_done_i ? (rxdet_result_i & lane_en_i) : '0;
    assign decide = rxdet_done_i || (timer_q == TO_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= QUIET;
            timer_q <= '0;
            first_q <= '0;
            lanes_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            first_q <= first_d;
            lanes_q <= lanes_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        lanes_d = lanes_q;
        pulse_d = 1'b0;

        case (state_q)
            QUIET: begin
                if ((timer_q == Q_LAST) || (|(~elec_idle_i & lane_en_i))) begin
                    state_d = ACTIVE1;
                end
            end
            ACTIVE1: begin
                if (decide) begin
                    if ((lane_en_i == '0) || (r == '0)) begin
                        state_d = QUIET;
                    end else if (r == lane_en_i) begin
                        state_d = DONE;
                        lanes_d = r;
                        pulse_d = 1'b1;
                    end else begin
                        // Partial detect: remember which lanes answered and retry later.
                        state_d = WAIT;
                        first_d = r;
                    end
                end
            end
            WAIT: begin
                if (timer_q == Q_LAST) begin
                    state_d = ACTIVE2;
                end
            end
            ACTIVE2: begin
                if (decide) begin
                    // first_q is never zero here, so a timeout always falls back to QUIET.
                    if (r == first_q) begin
                        state_d = DONE;
                        lanes_d = r;
                        pulse_d = 1'b1;
                    end else begin
                        state_d = QUIET;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = QUIET;
            end
        endcase

        // Restart overrides every other transition, including a same-cycle done.
        if (restart_i) begin
            state_d = QUIET;
            first_d = '0;
            lanes_d = '0;
            pulse_d = 1'b0;
        end

        if (restart_i || (state_d != state_q)) begin
            timer_d = '0;
        end else if (timer_q != T_MAX) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end
    end

    // The request follows the state directly, so it drops on the edge that consumes done.
    assign rxdet_req_o      = (state_q == ACTIVE1) || (state_q == ACTIVE2);
    assign active_o         = (state_q == ACTIVE1) || (state_q == ACTIVE2);
    assign detect_done_o    = pulse_q;
    assign lanes_detected_o = lanes_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_ltssm_detect_multi.sv
module tb_ltssm_detect_multi;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       restart_i;
    logic [3:0] lane_en_i;
    logic [3:0] elec_idle_i;
    logic       rxdet_req_o;
    logic       rxdet_done_i;
    logic [3:0] rxdet_result_i;
    logic       active_o;
    logic       detect_done_o;
    logic [3:0] lanes_detected_o;
    logic [2:0] state_o;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] S_QUIET = 3'd0, S_ACT1 = 3'd1, S_WAIT = 3'd2,
                           S_ACT2 = 3'd3, S_DONE = 3'd4;

    ltssm_detect_multi #(
        .NUM_LANES(4), .QUIET_CYCLES(20), .RXDET_TIMEOUT(8)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .restart_i(restart_i),
        .lane_en_i(lane_en_i), .elec_idle_i(elec_idle_i),
        .rxdet_req_o(rxdet_req_o), .rxdet_done_i(rxdet_done_i),
        .rxdet_result_i(rxdet_result_i), .active_o(active_o),
        .detect_done_o(detect_done_o), .lanes_detected_o(lanes_detected_o),
        .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic done_pulse(input logic [3:0] res);
        rxdet_done_i   = 1'b1;
        rxdet_result_i = res;
        step(1);
        rxdet_done_i   = 1'b0;
        rxdet_result_i = 4'h0;
    endtask

    task automatic do_restart();
        elec_idle_i = 4'hF;
        restart_i   = 1'b1;
        step(1);
        restart_i   = 1'b0;
    endtask

    // Enter ACTIVE1 quickly through an electrical-idle exit on lane 0.
    task automatic enter_active1();
        elec_idle_i = 4'hE;
        step(1);
        elec_idle_i = 4'hF;
    endtask

    initial begin
        rst_ni         = 1'b0;
        restart_i      = 1'b0;
        lane_en_i      = 4'hF;
        elec_idle_i    = 4'hF;
        rxdet_done_i   = 1'b0;
        rxdet_result_i = 4'h0;
        step(2);
        chk("rst_state", state_o, S_QUIET);
        chk("rst_req", rxdet_req_o, 0);
        chk("rst_active", active_o, 0);
        chk("rst_done", detect_done_o, 0);
        chk("rst_lanes", lanes_detected_o, 0);
        rst_ni = 1'b1;

        // Quiet interval expiry
        step(19);
        chk("quiet19_state", state_o, S_QUIET);
        chk("quiet19_req", rxdet_req_o, 0);
        step(1);
        chk("quiet20_state", state_o, S_ACT1);
        chk("quiet20_req", rxdet_req_o, 1);
        chk("quiet20_active", active_o, 1);
        done_pulse(4'hF);
        chk("full_state", state_o, S_DONE);
        chk("full_pulse", detect_done_o, 1);
        chk("full_lanes", lanes_detected_o, 4'hF);
        chk("full_req", rxdet_req_o, 0);
        step(1);
        chk("full_pulse_end", detect_done_o, 0);
        chk("full_hold_state", state_o, S_DONE);
        chk("full_hold_lanes", lanes_detected_o, 4'hF);
        do_restart();
        chk("restart_state", state_o, S_QUIET);
        chk("restart_lanes", lanes_detected_o, 0);

        // Done while not active is ignored
        done_pulse(4'hF);
        chk("idle_done_state", state_o, S_QUIET);
        chk("idle_done_pulse", detect_done_o, 0);

        // Electrical-idle exit
        do_restart();
        step(5);
        chk("eidle_pre", state_o, S_QUIET);
        elec_idle_i = 4'hB;
        step(1);
        elec_idle_i = 4'hF;
        chk("eidle_exit", state_o, S_ACT1);
        done_pulse(4'hF);
        chk("eidle_state", state_o, S_DONE);
        chk("eidle_pulse", detect_done_o, 1);
        chk("eidle_lanes", lanes_detected_o, 4'hF);

        // Partial detect, matching retry
        do_restart();
        enter_active1();
        done_pulse(4'h3);
        chk("part_wait", state_o, S_WAIT);
        chk("part_wait_req", rxdet_req_o, 0);
        chk("part_wait_active", active_o, 0);
        elec_idle_i = 4'h0;
        step(19);
        chk("part_wait19", state_o, S_WAIT);
        step(1);
        elec_idle_i = 4'hF;
        chk("part_act2", state_o, S_ACT2);
        chk("part_act2_req", rxdet_req_o, 1);
        done_pulse(4'h3);
        chk("part_done_state", state_o, S_DONE);
        chk("part_done_pulse", detect_done_o, 1);
        chk("part_done_lanes", lanes_detected_o, 4'h3);

        // Partial detect, mismatching retry
        do_restart();
        enter_active1();
        done_pulse(4'h3);
        chk("mis_wait", state_o, S_WAIT);
        step(20);
        chk("mis_act2", state_o, S_ACT2);
        done_pulse(4'h1);
        chk("mis_state", state_o, S_QUIET);
        chk("mis_lanes", lanes_detected_o, 0);
        chk("mis_pulse", detect_done_o, 0);

        // Timeout in ACTIVE1
        do_restart();
        enter_active1();
        step(7);
        chk("to7_state", state_o, S_ACT1);
        chk("to7_req", rxdet_req_o, 1);
        step(1);
        chk("to8_state", state_o, S_QUIET);
        chk("to8_req", rxdet_req_o, 0);

        // Empty result
        enter_active1();
        done_pulse(4'h0);
        chk("zero_state", state_o, S_QUIET);

        // Restart coincident with done
        enter_active1();
        rxdet_done_i   = 1'b1;
        rxdet_result_i = 4'hF;
        restart_i      = 1'b1;
        step(1);
        rxdet_done_i   = 1'b0;
        restart_i      = 1'b0;
        chk("rs_done_state", state_o, S_QUIET);
        chk("rs_done_pulse", detect_done_o, 0);
        chk("rs_done_lanes", lanes_detected_o, 0);
        chk("rs_done_req", rxdet_req_o, 0);

        // Asynchronous reset in WAIT
        enter_active1();
        done_pulse(4'h3);
        step(5);
        chk("wait_before_rst", state_o, S_WAIT);
        rst_ni = 1'b0;
        #1;
        chk("arst_state", state_o, S_QUIET);
        chk("arst_lanes", lanes_detected_o, 0);
        chk("arst_active", active_o, 0);
        chk("arst_req", rxdet_req_o, 0);
        lane_en_i = 4'h0;
        step(1);
        rst_ni = 1'b1;

        // No enabled lanes: idle exit disabled, and ACTIVE1 never reaches DONE
        elec_idle_i = 4'h0;
        step(19);
        chk("noen_quiet", state_o, S_QUIET);
        step(1);
        chk("noen_act1", state_o, S_ACT1);
        done_pulse(4'hF);
        chk("noen_state", state_o, S_QUIET);
        chk("noen_pulse", detect_done_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
